uart_tx_fifo: RTL and testbench

- Parametrised successor to the single-byte UART transmitter: configurable data width, parity and stop bits, fronted by a small transmit FIFO.
- Software or upstream logic can queue several characters back-to-back without waiting for o_TX_Done.
- Sits between a byte producer and the serial line; drives the line directly, idle-high.

---
 rtl/uart_tx_fifo.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits,
// fronted by a small power-of-two FIFO so a producer can queue several characters.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_TX_DV,
    input  logic [DATA_BITS-1:0]          i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Overflow,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam int FIFO_DEPTH_I = FIFO_DEPTH;
    localparam logic [PTR_W:0]     FULL_COUNT = FIFO_DEPTH_I[PTR_W:0];
    localparam logic [CNT_W-1:0]   CLK_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]   STOP_LAST  = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_CLEANUP
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       clkCnt_q;
    logic [BIT_W-1:0]       bitCnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   serial_q;
    logic                   active_q;
    logic                   done_q;
    logic                   ready_q;
    logic                   overflow_q;

    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wrPtr_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [PTR_W:0]         count_q;
    logic [PTR_W:0]         count_d;

    logic                   full;
    logic                   empty;
    logic                   pushEn;
    logic                   popEn;
    logic                   bitEnd;
    logic                   headParity;
    logic                   lineBit;
    logic [DATA_BITS-1:0]   headData;

    assign full       = (count_q == FULL_COUNT);
    assign empty      = (count_q == '0);
    assign pushEn     = i_TX_DV && !full;
    assign popEn      = ((state_q == S_IDLE) || (state_q == S_CLEANUP)) && !empty;
    assign bitEnd     = (clkCnt_q == CLK_LAST);
    assign headData   = mem_q[rdPtr_q];
    assign headParity = (PARITY == 1) ? ~(^headData) : (^headData);

    assign o_TX_Ready    = ready_q;
    assign o_FIFO_Count  = count_q;
    assign o_TX_Overflow = overflow_q;
    assign o_TX_Active   = active_q;
    assign o_TX_Serial   = serial_q;
    assign o_TX_Done     = done_q;

    always_comb begin
        count_d = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (popEn && !pushEn) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        lineBit = 1'b1;
        case (state_q)
            S_START:  lineBit = 1'b0;
            S_DATA:   lineBit = shift_q[0];
            S_PARITY: lineBit = parity_q;
            default:  lineBit = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= i_TX_Byte;
        end
    end

    // A push while full is dropped and flagged even if a pop frees a slot this cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q    <= count_d;
            ready_q    <= (count_d != FULL_COUNT);
            overflow_q <= i_TX_DV && full;
        end
    end

    // Line outputs follow the state one cycle later, so every output is a flop.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= S_IDLE;
            clkCnt_q <= '0;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            serial_q <= lineBit;
            active_q <= (state_q != S_IDLE);
            done_q   <= (state_q == S_CLEANUP);
            case (state_q)
                S_IDLE, S_CLEANUP: begin
                    clkCnt_q <= '0;
                    bitCnt_q <= '0;
                    if (popEn) begin
                        shift_q  <= headData;
                        parity_q <= headParity;
                        state_q  <= S_START;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_START: begin
                    if (bitEnd) begin
                        clkCnt_q <= '0;
                        state_q  <= S_DATA;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bitEnd) begin
                        clkCnt_q <= '0;
                        shift_q  <= shift_q >> 1;
                        if (bitCnt_q == DATA_LAST) begin
                            bitCnt_q <= '0;
                            state_q  <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bitEnd) begin
                        clkCnt_q <= '0;
                        state_q  <= S_STOP;
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bitEnd) begin
                        clkCnt_q <= '0;
                        if (bitCnt_q == STOP_LAST) begin
                            bitCnt_q <= '0;
                            state_q  <= S_CLEANUP;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three configurations (8N1, 7E2, 9O1 at two clocks per bit),
// a loopback-style frame decoder per instance compares against queued expectations.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstA, rstO;
    logic       dvA, dvB, dvC;
    logic [7:0] byteA;
    logic [6:0] byteB;
    logic [8:0] byteC;

    logic       rdyA, ovfSigA, actA, serA, doneSigA;
    logic       rdyB, ovfSigB, actB, serB, doneSigB;
    logic       rdyC, ovfSigC, actC, serC, doneSigC;
    logic [2:0] cntA, cntB;
    logic [1:0] cntC;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
        .i_Clock(clk), .i_Reset(rstA), .i_TX_DV(dvA), .i_TX_Byte(byteA),
        .o_TX_Ready(rdyA), .o_FIFO_Count(cntA), .o_TX_Overflow(ovfSigA),
        .o_TX_Active(actA), .o_TX_Serial(serA), .o_TX_Done(doneSigA));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dutB (
        .i_Clock(clk), .i_Reset(rstO), .i_TX_DV(dvB), .i_TX_Byte(byteB),
        .o_TX_Ready(rdyB), .o_FIFO_Count(cntB), .o_TX_Overflow(ovfSigB),
        .o_TX_Active(actB), .o_TX_Serial(serB), .o_TX_Done(doneSigB));

    uart_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) dutC (
        .i_Clock(clk), .i_Reset(rstO), .i_TX_DV(dvC), .i_TX_Byte(byteC),
        .o_TX_Ready(rdyC), .o_FIFO_Count(cntC), .o_TX_Overflow(ovfSigC),
        .o_TX_Active(actC), .o_TX_Serial(serC), .o_TX_Done(doneSigC));

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int passes = 0;
    int expA[$], expB[$], expC[$];
    int fallsA[$];
    bit abortA = 1'b1, abortO = 1'b1;
    bit statsOn = 1'b0, gapOn = 1'b0;
    int fallBase = 0;
    int ovfCntA = 0, maxCountA = 0, readyLowA = 0, doneCntA = 0, gapA = 0;

    always @(negedge clk) begin
        if (statsOn) begin
            ovfCntA += int'(ovfSigA);
            if (int'(cntA) > maxCountA) maxCountA = int'(cntA);
            if (!rdyA) readyLowA++;
            if (gapOn && fallsA.size() > fallBase && doneCntA < 5 && !actA) gapA++;
            doneCntA += int'(doneSigA);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic logic lineOf(input int w);
        case (w)
            0: return serA;
            1: return serB;
            default: return serC;
        endcase
    endfunction

    function automatic logic doneOf(input int w);
        case (w)
            0: return doneSigA;
            1: return doneSigB;
            default: return doneSigC;
        endcase
    endfunction

    function automatic logic activeOf(input int w);
        case (w)
            0: return actA;
            1: return actB;
            default: return actC;
        endcase
    endfunction

    function automatic bit abortOf(input int w);
        return (w == 0) ? abortA : abortO;
    endfunction

    function automatic int expSize(input int w);
        case (w)
            0: return expA.size();
            1: return expB.size();
            default: return expC.size();
        endcase
    endfunction

    task automatic popExp(input int w, output int e, output bit ok);
        ok = (expSize(w) != 0);
        e = 0;
        if (ok) begin
            case (w)
                0: e = expA.pop_front();
                1: e = expB.pop_front();
                default: e = expC.pop_front();
            endcase
        end
    endtask

    // Called at posedge+1; holds the strobe for exactly one sampling edge.
    task automatic applyStimulus(input int w, input int value, input int parity, input bit expectSent);
        int e;
        e = value | (parity << 16);
        case (w)
            0: begin byteA = value[7:0]; dvA = 1'b1; if (expectSent) expA.push_back(e); end
            1: begin byteB = value[6:0]; dvB = 1'b1; if (expectSent) expB.push_back(e); end
            default: begin byteC = value[8:0]; dvC = 1'b1; if (expectSent) expC.push_back(e); end
        endcase
        @(posedge clk); #1;
        dvA = 1'b0; dvB = 1'b0; dvC = 1'b0;
    endtask

    task automatic nextPos(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic waitDrain(input int w, input int budget);
        int n;
        n = 0;
        while ((expSize(w) != 0 || activeOf(w) !== 1'b0) && n < budget) begin
            nextPos(1);
            n++;
        end
        checkOutput($sformatf("DUT%0d drain within budget", w), int'(n < budget), 1);
    endtask

    // Decodes one frame from its start bit, sampling mid-bit, and checks Done lands at fall+F.
    task automatic monitorFrames(input int w, input int c, input int d, input int p, input int s);
        int f, j, stopHigh, earlyDone, e;
        logic [8:0] data;
        logic startBit, parBit, doneEnd, b;
        bit aborted, ok;
        f = (1 + d + ((p != 0) ? 1 : 0) + s) * c;
        forever begin
            @(negedge clk);
            if (!abortOf(w) && lineOf(w) === 1'b0) begin
                if (w == 0) fallsA.push_back(cycle);
                data = '0; startBit = 1'b1; parBit = 1'b0; doneEnd = 1'b0;
                stopHigh = 0; earlyDone = 0; aborted = 1'b0;
                for (int t = 0; t <= f; t++) begin
                    if (t > 0) @(negedge clk);
                    if (abortOf(w)) begin aborted = 1'b1; break; end
                    if (t % c == c / 2) begin
                        j = t / c;
                        b = lineOf(w);
                        if (j == 0) startBit = b;
                        else if (j <= d) data[j-1] = b;
                        else if (p != 0 && j == d + 1) parBit = b;
                        else stopHigh += int'(b);
                    end
                    if (t < f && doneOf(w) === 1'b1) earlyDone++;
                    if (t == f) doneEnd = doneOf(w);
                end
                if (!aborted) begin
                    popExp(w, e, ok);
                    checkOutput($sformatf("DUT%0d frame was expected", w), int'(ok), 1);
                    if (ok) begin
                        checkOutput($sformatf("DUT%0d start bit", w), int'(startBit), 0);
                        checkOutput($sformatf("DUT%0d data", w), int'(data), e & 'h1FF);
                        if (p != 0) checkOutput($sformatf("DUT%0d parity", w), int'(parBit), (e >> 16) & 1);
                        checkOutput($sformatf("DUT%0d stop bits high", w), stopHigh, s);
                        checkOutput($sformatf("DUT%0d done at fall+F", w), int'(doneEnd), 1);
                        checkOutput($sformatf("DUT%0d no early done", w), earlyDone, 0);
                    end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, kX, doneSnap;
        rstA = 1'b1; rstO = 1'b1;
        dvA = 1'b0; dvB = 1'b0; dvC = 1'b0;
        byteA = '0; byteB = '0; byteC = '0;
        fork
            monitorFrames(0, 4, 8, 0, 1);
            monitorFrames(1, 4, 7, 2, 2);
            monitorFrames(2, 2, 9, 1, 1);
        join_none

        nextPos(3);
        rstA = 1'b0; rstO = 1'b0;
        @(negedge clk);
        checkOutput("reset serial", int'(serA), 1);
        checkOutput("reset active", int'(actA), 0);
        checkOutput("reset done", int'(doneSigA), 0);
        checkOutput("reset overflow", int'(ovfSigA), 0);
        checkOutput("reset count", int'(cntA), 0);
        checkOutput("reset ready", int'(rdyA), 1);
        checkOutput("reset B count/ready/ovf", int'({cntB, rdyB, ovfSigB}), 2);
        checkOutput("reset C count/ready/ovf/serial", int'({cntC, rdyC, ovfSigC, serC}), 5);
        nextPos(1);
        abortA = 1'b0; abortO = 1'b0; statsOn = 1'b1;

        // Latency from an idle, empty FIFO: line falls after the second edge past the push.
        applyStimulus(0, 'h3F, 0, 1'b1);
        @(negedge clk);
        checkOutput("latency edge k serial", int'(serA), 1);
        checkOutput("count after push", int'(cntA), 1);
        @(negedge clk);
        checkOutput("latency edge k+1 serial", int'(serA), 1);
        @(negedge clk);
        checkOutput("latency edge k+2 serial", int'(serA), 0);
        nextPos(1);
        waitDrain(0, 200);

        // Parity and stop-bit variants.
        applyStimulus(1, 'h55, 0, 1'b1);
        applyStimulus(1, 'h54, 1, 1'b1);
        applyStimulus(1, 'h25, 1, 1'b1);
        applyStimulus(2, 'h055, 1, 1'b1);
        applyStimulus(2, 'h1FF, 0, 1'b1);
        waitDrain(2, 200);
        applyStimulus(2, 'h100, 0, 1'b1);
        applyStimulus(2, 'h003, 1, 1'b1);
        waitDrain(2, 200);
        waitDrain(1, 300);

        // Burst of six into a four-deep FIFO.
        ovfCntA = 0; maxCountA = 0; readyLowA = 0; doneCntA = 0; gapA = 0;
        fallBase = fallsA.size(); gapOn = 1'b1;
        for (int i = 1; i <= 6; i++) applyStimulus(0, i, 0, i <= 5);
        waitDrain(0, 400);
        nextPos(60);
        gapOn = 1'b0;
        checkOutput("burst overflow pulses", ovfCntA, 1);
        checkOutput("burst peak count", maxCountA, 4);
        checkOutput("burst ready deasserted", int'(readyLowA > 0), 1);
        checkOutput("burst done pulses", doneCntA, 5);
        checkOutput("burst frames sent", fallsA.size() - fallBase, 5);
        checkOutput("burst active gaps", gapA, 0);
        for (int i = 1; i < 5 && fallBase + i < fallsA.size(); i++)
            checkOutput($sformatf("burst spacing %0d", i), fallsA[fallBase+i] - fallsA[fallBase+i-1], 41);

        // Reset mid-DATA with two entries queued.
        base = fallsA.size();
        applyStimulus(0, 'h11, 0, 1'b1);
        applyStimulus(0, 'h22, 0, 1'b1);
        applyStimulus(0, 'h33, 0, 1'b1);
        nextPos(12);
        @(negedge clk);
        checkOutput("queued before reset", int'(cntA), 2);
        nextPos(1);
        abortA = 1'b1; rstA = 1'b1;
        nextPos(1);
        rstA = 1'b0;
        @(negedge clk);
        checkOutput("post-reset serial", int'(serA), 1);
        checkOutput("post-reset active", int'(actA), 0);
        checkOutput("post-reset count", int'(cntA), 0);
        checkOutput("post-reset done", int'(doneSigA), 0);
        checkOutput("post-reset ready", int'(rdyA), 1);
        nextPos(1);
        expA.delete();
        doneSnap = doneCntA;
        nextPos(3);
        abortA = 1'b0;
        nextPos(80);
        checkOutput("no done for aborted frame", doneCntA - doneSnap, 0);
        checkOutput("no frame after reset", fallsA.size() - base, 1);
        applyStimulus(0, 'h3C, 0, 1'b1);
        waitDrain(0, 200);

        // Push lands on the CLEANUP pop while one entry is queued.
        base = fallsA.size();
        applyStimulus(0, 'h81, 0, 1'b1);
        kX = cycle;
        applyStimulus(0, 'h42, 0, 1'b1);
        while (cycle < kX + 41) nextPos(1);
        applyStimulus(0, 'h9A, 0, 1'b1);
        @(negedge clk);
        checkOutput("count across cleanup push/pop", int'(cntA), 1);
        nextPos(1);
        waitDrain(0, 400);
        checkOutput("cleanup frames sent", fallsA.size() - base, 3);
        if (fallsA.size() - base == 3) begin
            checkOutput("cleanup spacing 1", fallsA[base+1] - fallsA[base], 41);
            checkOutput("cleanup spacing 2", fallsA[base+2] - fallsA[base+1], 41);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
